// File: rtl/sdram_arb_pkg.sv
// Shared types and default widths for the SDRAM arbiter.
// Imported by the arbiter top and its round-robin picker.
package sdram_arb_pkg;

  localparam int SDRAM_ADDR_W = 25;
  localparam int SDRAM_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RELEASE
  } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: lowest distance after `last` wins, with wrap.
// Purely combinational; `any` flags that some client is requesting.
import sdram_arb_pkg::*;

module rr_picker #(
  parameter int N  = 2,
  parameter int LW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [LW-1:0] last,
  output logic [N-1:0]  win,
  output logic [LW-1:0] idx,
  output logic          any
);

  int d;
  int best;

  always_comb begin
    d    = 0;
    best = N;
    idx  = '0;
    any  = |req;
    for (int i = 0; i < N; i++) begin
      if (req[i]) begin
        d = (i + N - 1 - int'(last)) % N;
        if (d < best) begin
          best = d;
          idx  = LW'(i);
        end
      end
    end
    win = '0;
    for (int i = 0; i < N; i++) begin
      win[i] = any && (idx == LW'(i));
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// N-client round-robin arbiter in front of the single SDRAM controller.
// Optional transaction watchdog: define SDRAM_ARB_TIMEOUT_EN.
import sdram_arb_pkg::*;

module sdram_arbiter #(
  parameter int N_CLIENTS      = 2,
  parameter int ADDR_W         = SDRAM_ADDR_W,
  parameter int DATA_W         = SDRAM_DATA_W,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                        Clk,
  input  logic                        Reset_n,
  input  logic [N_CLIENTS-1:0]        req,
  input  logic [N_CLIENTS*ADDR_W-1:0] addr,
  input  logic [N_CLIENTS*DATA_W-1:0] din,
  input  logic [N_CLIENTS-1:0]        we,
  output logic [N_CLIENTS-1:0]        gnt,
  output logic [N_CLIENTS-1:0]        done,
  output logic [N_CLIENTS-1:0]        err,
  output logic [DATA_W-1:0]           Dout,
  output logic [ADDR_W-1:0]           ctl_Addr,
  output logic [DATA_W-1:0]           ctl_Din,
  output logic                        ctl_WE,
  output logic                        ctl_Act,
  input  logic                        ctl_R,
  input  logic [DATA_W-1:0]           ctl_Dout
);

  localparam int LW = $clog2(N_CLIENTS);

  arb_state_t state;
  arb_state_t state_nx;

  logic [LW-1:0]        last;
  logic [N_CLIENTS-1:0] win;
  logic [LW-1:0]        win_idx;
  logic                 any;

  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_din;
  logic              sel_we;
  logic              tmo;
  logic              finish;

  rr_picker #(
    .N  (N_CLIENTS),
    .LW (LW)
  ) u_pick (
    .req  (req),
    .last (last),
    .win  (win),
    .idx  (win_idx),
    .any  (any)
  );

  // route the winning client's request fields
  always_comb begin
    sel_addr = '0;
    sel_din  = '0;
    sel_we   = 1'b0;
    for (int i = 0; i < N_CLIENTS; i++) begin
      if (win[i]) begin
        sel_addr = addr[i*ADDR_W +: ADDR_W];
        sel_din  = din[i*DATA_W +: DATA_W];
        sel_we   = we[i];
      end
    end
  end

`ifdef SDRAM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES);

  logic [CW-1:0] cnt;

  // BUSY cycles without a controller response
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt <= '0;
    end else if (state != BUSY) begin
      cnt <= '0;
    end else if (!ctl_R) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tmo = (state == BUSY) && !ctl_R &&
               (cnt == CW'(TIMEOUT_CYCLES - 1));

  // abort pulse to the owner when the watchdog fires
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      err <= '0;
    end else begin
      err <= tmo ? gnt : '0;
    end
  end
`else
  // no watchdog: a transaction waits for the controller forever
  assign tmo = (TIMEOUT_CYCLES < 0);
  assign err = '0;
`endif

  assign finish = (state == BUSY) && (ctl_R || tmo);

  // state register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // next state
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (any) state_nx = BUSY;
      BUSY:    if (finish) state_nx = RELEASE;
      RELEASE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // grant, controller drive, completion and read data
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      gnt      <= '0;
      done     <= '0;
      Dout     <= '0;
      ctl_Addr <= '0;
      ctl_Din  <= '0;
      ctl_WE   <= 1'b0;
      ctl_Act  <= 1'b0;
      last     <= LW'(N_CLIENTS - 1);
    end else begin
      done <= '0;
      if (state == IDLE && any) begin
        ctl_Addr <= sel_addr;
        ctl_Din  <= sel_din;
        ctl_WE   <= sel_we;
        ctl_Act  <= 1'b1;
        gnt      <= win;
        last     <= win_idx;
      end
      if (finish) begin
        done    <= gnt;
        gnt     <= '0;
        ctl_Act <= 1'b0;
        if (ctl_R && !ctl_WE) begin
          Dout <= ctl_Dout;
        end
      end
    end
  end

endmodule
